// File: rtl/data_memory_mmio_if.sv
// Load/store bus between the CPU memory stage and data_memory_mmio.
// The master drives requests; the slave returns registered load data and status pulses.
interface data_memory_mmio_if;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  length;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        rvalid;
    logic        misalign;

    modport master (
        output MemRead, MemWrite, length, sign, addr, din,
        input  dout, rvalid, misalign
    );

    modport slave (
        input  MemRead, MemWrite, length, sign, addr, din,
        output dout, rvalid, misalign
    );
endinterface

// File: rtl/data_memory_mmio.sv
// Byte/half/word data memory with a memory-mapped switch/LED/button IO region.
// Loads are registered: dout and rvalid update one clock after an accepted read.
module data_memory_mmio #(
    parameter int DEPTH_WORDS = 16384,
    parameter int IO_CH       = 2,
    parameter int DEBOUNCE    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    data_memory_mmio_if.slave     bus,
    input  logic [16*IO_CH-1:0]   sw_in,
    output logic [16*IO_CH-1:0]   led_out,
    input  logic                  btn
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(DEBOUNCE + 1);

    logic [31:0]   mem [DEPTH_WORDS];
    logic [15:0]   led [IO_CH];
    logic [AW-1:0] idx;
    logic          is_io;
    logic [1:0]    cls;
    logic [1:0]    ch;
    logic [1:0]    off;
    logic          ch_valid;
    logic          misaligned;
    logic          rd_ok;
    logic          wr_ok;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [15:0]   sw_sel;
    logic [15:0]   led_sel;
    logic [31:0]   io_word;
    logic [31:0]   rd_word;
    logic          status_rd;
    logic          sync1, sync2, level, press, rise;
    logic [CW-1:0] cnt;
    logic [31:0]   dout_p1;
    logic          vld_p1;
    logic          misalign_p1;
    logic          unused_addr;

    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] sh,
                                            input logic [1:0] len, input logic sgn);
        logic [31:0] s;
        s = word >> {sh, 3'b000};
        case (len)
            2'd0:    extract = {{24{sgn & s[7]}}, s[7:0]};
            2'd1:    extract = {{16{sgn & s[15]}}, s[15:0]};
            default: extract = s;
        endcase
    endfunction

    assign idx         = bus.addr[AW+1:2];
    assign is_io       = bus.addr[31];
    assign cls         = bus.addr[5:4];
    assign ch          = bus.addr[3:2];
    assign off         = bus.addr[1:0];
    assign ch_valid    = {30'b0, ch} < 32'(IO_CH);
    assign unused_addr = ^bus.addr[30:AW+2];

    assign misaligned = (bus.length == 2'd3)
                      | (bus.length == 2'd1 && off[0])
                      | (bus.length == 2'd2 && off != 2'd0);
    assign rd_ok = bus.MemRead  & ~misaligned;
    assign wr_ok = bus.MemWrite & ~misaligned;

    // Lane enables and replicated store data
    always_comb begin
        be    = 4'hF;
        wdata = bus.din;
        case (bus.length)
            2'd0: begin
                be    = 4'b0001 << off;
                wdata = {4{bus.din[7:0]}};
            end
            2'd1: begin
                be    = 4'b0011 << off;
                wdata = {2{bus.din[15:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_ok && !is_io) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < IO_CH; k++) led[k] <= '0;
        end else if (wr_ok && is_io && cls == 2'd1 && ch_valid) begin
            for (int k = 0; k < IO_CH; k++) begin
                if (ch == 2'(k)) begin
                    if (be[0]) led[k][7:0]  <= wdata[7:0];
                    if (be[1]) led[k][15:8] <= wdata[15:8];
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < IO_CH; k++) led_out[16*k +: 16] = led[k];
    end

    always_comb begin
        sw_sel  = '0;
        led_sel = '0;
        io_word = '0;
        for (int k = 0; k < IO_CH; k++) begin
            if (ch == 2'(k)) begin
                sw_sel  = sw_in[16*k +: 16];
                led_sel = led[k];
            end
        end
        if (ch_valid) begin
            case (cls)
                2'd0:    io_word = {16'b0, sw_sel};
                2'd1:    io_word = {16'b0, led_sel};
                2'd2:    io_word = {30'b0, press, level};
                default: io_word = '0;
            endcase
        end
    end

    assign rd_word   = is_io ? io_word : mem[idx];
    assign status_rd = rd_ok & is_io & (cls == 2'd2) & ch_valid;

    // Stage p1: registered load result and status pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_p1     <= '0;
            vld_p1      <= 1'b0;
            misalign_p1 <= 1'b0;
        end else begin
            vld_p1      <= bus.MemRead;
            misalign_p1 <= (bus.MemRead | bus.MemWrite) & misaligned;
            if (rd_ok) dout_p1 <= extract(rd_word, off, bus.length, bus.sign);
        end
    end

    assign bus.dout     = dout_p1;
    assign bus.rvalid   = vld_p1;
    assign bus.misalign = misalign_p1;

    // Debounced level toggles on the DEBOUNCE-th consecutive differing sample
    assign rise = sync2 & ~level & (cnt == CW'(DEBOUNCE - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE - 1)) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (rise)           press <= 1'b1;
            else if (status_rd) press <= 1'b0;
        end
    end
endmodule

// File: tb/tb_data_memory_mmio.sv
// Directed-vector bench for data_memory_mmio: RAM lanes, alignment faults, IO region,
// button debounce/press flag and asynchronous reset.
module tb_data_memory_mmio;
    localparam int IO_CH    = 2;
    localparam int DEBOUNCE = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [16*IO_CH-1:0] sw_in = '0;
    logic [16*IO_CH-1:0] led_out;
    logic                btn = 1'b0;
    int                  n_tests = 0;
    int                  n_fail  = 0;

    data_memory_mmio_if bus ();

    data_memory_mmio #(.DEPTH_WORDS(16384), .IO_CH(IO_CH), .DEBOUNCE(DEBOUNCE)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .sw_in   (sw_in),
        .led_out (led_out),
        .btn     (btn)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one request for a single clock; outputs are sampled 1 time unit after the edge.
    task automatic op(input logic rd, input logic wr, input logic [1:0] len, input logic sgn,
                      input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.MemRead  = rd;
        bus.MemWrite = wr;
        bus.length   = len;
        bus.sign     = sgn;
        bus.addr     = a;
        bus.din      = d;
        @(posedge clk);
        #1;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.length   = 2'd0;
        bus.sign     = 1'b0;
        bus.addr     = '0;
        bus.din      = '0;
        #12;
        check("rst_dout",     bus.dout,          32'h0);
        check("rst_rvalid",   32'(bus.rvalid),   32'h0);
        check("rst_misalign", 32'(bus.misalign), 32'h0);
        check("rst_led",      led_out,           32'h0);
        @(negedge clk);
        rst = 1'b1;

        op(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF);
        op(1, 0, 2'd1, 1, 32'h12, 32'h0);
        check("half_sx_dout",   bus.dout,        32'hFFFFDEAD);
        check("half_sx_rvalid", 32'(bus.rvalid), 32'h1);
        idle(1);
        check("rvalid_one_cyc", 32'(bus.rvalid), 32'h0);
        check("dout_hold",      bus.dout,        32'hFFFFDEAD);

        op(0, 1, 2'd0, 0, 32'h11, 32'h0000005A);
        op(1, 0, 2'd2, 0, 32'h10, 32'h0);
        check("byte_merge", bus.dout, 32'hDEAD5AEF);
        op(1, 0, 2'd0, 0, 32'h11, 32'h0);
        check("byte_zx", bus.dout, 32'h0000005A);

        op(0, 1, 2'd1, 0, 32'h13, 32'h0000FFFF);
        check("mis_half_wr",     32'(bus.misalign), 32'h1);
        check("mis_half_wr_vld", 32'(bus.rvalid),   32'h0);
        op(1, 0, 2'd2, 0, 32'h22, 32'h0);
        check("mis_word_rd",     32'(bus.misalign), 32'h1);
        check("mis_word_rd_vld", 32'(bus.rvalid),   32'h1);
        check("mis_dout_keep",   bus.dout,          32'h0000005A);
        op(0, 1, 2'd3, 0, 32'h10, 32'h12345678);
        check("mis_len3", 32'(bus.misalign), 32'h1);
        idle(1);
        check("mis_one_cyc", 32'(bus.misalign), 32'h0);
        op(1, 0, 2'd2, 0, 32'h10, 32'h0);
        check("ram_untouched", bus.dout, 32'hDEAD5AEF);

        sw_in = {16'h8421, 16'h1111};
        op(1, 0, 2'd0, 1, 32'h80000005, 32'h0);
        check("sw_byte_sx", bus.dout, 32'hFFFFFF84);
        op(0, 1, 2'd1, 0, 32'h80000010, 32'h00001234);
        check("led_write", led_out, 32'h00001234);
        op(1, 0, 2'd1, 0, 32'h80000010, 32'h0);
        check("led_read", bus.dout, 32'h00001234);
        op(1, 0, 2'd2, 0, 32'h8000000C, 32'h0);
        check("io_bad_ch", bus.dout, 32'h0);
        op(0, 1, 2'd2, 0, 32'h80000000, 32'hFFFFFFFF);
        op(1, 0, 2'd2, 0, 32'h80000000, 32'h0);
        check("sw_ro", bus.dout, 32'h00001111);

        op(0, 1, 2'd2, 0, 32'h40, 32'h11111111);
        op(1, 1, 2'd2, 0, 32'h40, 32'h22222222);
        check("read_first", bus.dout, 32'h11111111);
        op(1, 0, 2'd2, 0, 32'h40, 32'h0);
        check("after_rmw", bus.dout, 32'h22222222);

        @(negedge clk);
        bus.MemRead = 1'b1; bus.MemWrite = 1'b0; bus.length = 2'd2; bus.sign = 1'b0;
        bus.addr = 32'h10;
        @(negedge clk);
        check("b2b_vld0",  32'(bus.rvalid), 32'h1);
        check("b2b_dout0", bus.dout,        32'hDEAD5AEF);
        bus.addr = 32'h40;
        @(negedge clk);
        bus.MemRead = 1'b0;
        check("b2b_vld1",  32'(bus.rvalid), 32'h1);
        check("b2b_dout1", bus.dout,        32'h22222222);

        @(negedge clk);
        btn = 1'b1;
        repeat (DEBOUNCE - 1) @(negedge clk);
        btn = 1'b0;
        idle(8);
        op(1, 0, 2'd2, 0, 32'h80000020, 32'h0);
        check("btn_glitch", bus.dout, 32'h0);
        @(negedge clk);
        btn = 1'b1;
        repeat (DEBOUNCE + 2) @(negedge clk);
        idle(4);
        op(1, 0, 2'd2, 0, 32'h80000020, 32'h0);
        check("btn_press", bus.dout, 32'h3);
        op(1, 0, 2'd2, 0, 32'h80000020, 32'h0);
        check("btn_cleared", bus.dout, 32'h1);
        btn = 1'b0;

        @(negedge clk);
        bus.MemRead = 1'b1; bus.length = 2'd2; bus.addr = 32'h10;
        @(posedge clk);
        #1;
        check("pre_rst_vld", 32'(bus.rvalid), 32'h1);
        bus.addr = 32'h40;
        #2;
        rst = 1'b0;
        #1;
        check("arst_dout",   bus.dout,        32'h0);
        check("arst_rvalid", 32'(bus.rvalid), 32'h0);
        check("arst_led",    led_out,         32'h0);
        bus.MemRead = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        idle(1);
        check("no_vld_after_rst", 32'(bus.rvalid), 32'h0);
        check("dout_after_rst",   bus.dout,        32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
